mmu_seq_ctrl: RTL and testbench
===============================

Name: mmu_seq_ctrl

Overview:
Sequencer for the 2x2 weight-stationary systolic matrix unit. On start it snapshots a 2x2 activation matrix A and a 2x2 weight matrix W, then pulses load_weight to the array. It feeds skewed activation rows, captures the accumulator outputs into a 2x2 result matrix C = A x W, and signals done. It sits between the host/register block and the array, and owns the array's load_weight, valid, a_in and weight inputs.

Parameters:
DATA_W, 16, width of activation and weight elements
ACC_W, 32, width of accumulator and result elements
CAP_OFFSET, 2, feed cycles from the first valid cycle to the first acc_out1 sample (array pipeline depth)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request a new multiply; accepted only in IDLE
a00,a01,a10,a11  in  DATA_W each  activation matrix A[row][col]
w00,w01,w10,w11  in  DATA_W each  weight matrix W[row][col]
busy  out  1  high in LOAD and FEED
done  out  1  one-cycle pulse in DONE
load_weight  out  1  to array
valid  out  1  to array
a_in1  out  DATA_W  to array row 0
a_in2  out  DATA_W  to array row 1
weight1,weight2,weight3,weight4  out  DATA_W each  to array PE(0,0),(0,1),(1,0),(1,1); driven from snapshot W00,W01,W10,W11
acc_out1  in  ACC_W  array column 0 result
acc_out2  in  ACC_W  array column 1 result
c00,c01,c10,c11  out  ACC_W each  result matrix C[row][col]

Behaviour:
- All outputs are registered. Reset (reset=0, asynchronous) forces state IDLE, counter 0, and every output to 0 (busy, done, load_weight, valid, a_in*, weight*, c*). Asserting reset mid-operation aborts the run. No done is issued, and the next start after release runs normally.
- States: IDLE -> LOAD -> FEED -> DONE -> IDLE.
- IDLE: on the edge where start=1, snapshot A and W into internal registers, drive weight1..4 from the W snapshot, and go to LOAD. Inputs A/W may change afterwards without effect.
- LOAD (1 cycle): load_weight=1, valid=0, a_in1=a_in2=0.
- FEED: NF = CAP_OFFSET+3 cycles, F0..F(NF-1); valid=1 and load_weight=0 throughout.
- Feed schedule (skew by one for row 1), with zero outside listed cycles:
  - F0: a_in1=A00, a_in2=0
  - F1: a_in1=A10, a_in2=A01
  - F2: a_in1=0, a_in2=A11
- Capture on the edge ending cycle Fk, with m=CAP_OFFSET:
  - c00 <= acc_out1 at k=m
  - c10 <= acc_out1 at k=m+1
  - c01 <= acc_out2 at k=m+1
  - c11 <= acc_out2 at k=m+2
- After the last FEED cycle, go to DONE.
- DONE (1 cycle): done=1, busy=0, valid=0. Return to IDLE.
- Result values: c* hold their values until overwritten by a later run. c* are not cleared at start.
- Latency: start edge to done high is NF+2 cycles (7 at default).
- start while busy or in DONE is ignored (not queued). A start in the same cycle done is high is also ignored; start is accepted in the following IDLE cycle.
- Arithmetic is performed in the array. The controller does no truncation; acc inputs are stored full ACC_W.
- weight1..4 stay at the last snapshot while not loading.

Test Plan:
- Basic multiply: A=[[1,2],[3,4]], W=[[5,6],[7,8]], behavioural 2x2 array model -> c00=19, c01=22, c10=43, c11=50; done pulses exactly 7 cycles after the start edge; busy high for 6 cycles.
- Sequence check: probe the array inputs from the same run -> load_weight high for exactly 1 cycle with weight1..4=5,6,7,8; then valid high for 5 cycles with (a_in1,a_in2) = (1,0), (3,2), (0,4), (0,0), (0,0).
- Ignored start: hold start=1 continuously from the first start -> runs are back-to-back with one IDLE cycle between done and the next LOAD. Change A to [[2,0],[0,2]] after the first snapshot -> first run still yields 19/22/43/50; second run yields 10/12/14/16.
- Reset mid-FEED: drop reset at F1 -> all outputs 0 immediately (asynchronously), no done pulse. After release, start with the basic operands -> correct 19/22/43/50.
- Extreme values: A all 16'hFFFF, W all 16'hFFFF, array model computing 32-bit unsigned products and sums -> each c equals 2*65535*65535 mod 2^32 = 32'hFFFC0002, captured unmodified.
- CAP_OFFSET=3: with the array model's depth increased by one -> correct results, FEED lasts 6 cycles, done at 8 cycles after start.

Source files
------------

// File: rtl/mmu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mmu_seq_ctrl
//  Purpose  : Sequencer for the 2x2 weight-stationary systolic matrix unit.
//             On an accepted start it snapshots the activation matrix A and
//             the weight matrix W. It pulses load_weight for one cycle and
//             then streams the skewed activation rows with valid high. It
//             captures the column accumulator outputs into C = A x W and
//             pulses done for one cycle.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                     clock, all logic on the rising edge
//    reset                   asynchronous, active-low reset
//    start                   request a multiply (accepted only in IDLE)
//    a00,a01,a10,a11         activation matrix A[row][col]
//    w00,w01,w10,w11         weight matrix W[row][col]
//    busy                    high while loading weights or feeding
//    done                    one-cycle completion pulse
//    load_weight, valid      array control
//    a_in1, a_in2            array activation inputs, rows 0 and 1
//    weight1..weight4        array weights for PE(0,0),(0,1),(1,0),(1,1)
//    acc_out1, acc_out2      array column 0 / column 1 accumulator results
//    c00,c01,c10,c11         result matrix C[row][col]
// ============================================================================
module mmu_seq_ctrl #(
    parameter int DATA_W     = 16,
    parameter int ACC_W      = 32,
    parameter int CAP_OFFSET = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] a00,
    input  logic [DATA_W-1:0] a01,
    input  logic [DATA_W-1:0] a10,
    input  logic [DATA_W-1:0] a11,
    input  logic [DATA_W-1:0] w00,
    input  logic [DATA_W-1:0] w01,
    input  logic [DATA_W-1:0] w10,
    input  logic [DATA_W-1:0] w11,
    output logic              busy,
    output logic              done,
    output logic              load_weight,
    output logic              valid,
    output logic [DATA_W-1:0] a_in1,
    output logic [DATA_W-1:0] a_in2,
    output logic [DATA_W-1:0] weight1,
    output logic [DATA_W-1:0] weight2,
    output logic [DATA_W-1:0] weight3,
    output logic [DATA_W-1:0] weight4,
    input  logic [ACC_W-1:0]  acc_out1,
    input  logic [ACC_W-1:0]  acc_out2,
    output logic [ACC_W-1:0]  c00,
    output logic [ACC_W-1:0]  c01,
    output logic [ACC_W-1:0]  c10,
    output logic [ACC_W-1:0]  c11
);

    // Number of feed cycles: three skewed activation slots plus the array
    // pipeline depth before the last column-1 result appears.
    localparam int NF    = CAP_OFFSET + 3;
    localparam int CNT_W = $clog2(NF + 1);

    localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_TWO  = CNT_W'(2);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(NF - 1);
    localparam logic [CNT_W-1:0] c_CAP0     = CNT_W'(CAP_OFFSET);
    localparam logic [CNT_W-1:0] c_CAP1     = CNT_W'(CAP_OFFSET + 1);
    localparam logic [CNT_W-1:0] c_CAP2     = CNT_W'(CAP_OFFSET + 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FEED = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;

    // Activation snapshot. The W snapshot lives directly in the weight
    // output registers, which hold it until the next accepted start.
    logic [DATA_W-1:0] r_a00;
    logic [DATA_W-1:0] r_a01;
    logic [DATA_W-1:0] r_a10;
    logic [DATA_W-1:0] r_a11;

    logic [DATA_W-1:0] r_w1;
    logic [DATA_W-1:0] r_w2;
    logic [DATA_W-1:0] r_w3;
    logic [DATA_W-1:0] r_w4;

    logic              r_busy;
    logic              r_done;
    logic              r_load_weight;
    logic              r_valid;
    logic [DATA_W-1:0] r_a_in1;
    logic [DATA_W-1:0] r_a_in2;

    logic [ACC_W-1:0]  r_c00;
    logic [ACC_W-1:0]  r_c01;
    logic [ACC_W-1:0]  r_c10;
    logic [ACC_W-1:0]  r_c11;

    // Next-cycle values of the registered outputs
    logic              w_snap;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_load_nxt;
    logic              w_valid_nxt;
    logic [DATA_W-1:0] w_a_in1_nxt;
    logic [DATA_W-1:0] w_a_in2_nxt;
    logic              w_cap_c00;
    logic              w_cap_c10_c01;
    logic              w_cap_c11;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= c_CNT_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next state, feed counter and next output values.
    // Outputs are registered, so they are decoded from the *next* state and
    // count; this makes each output valid in the cycle its state is active.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_snap        = 1'b0;
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        w_load_nxt    = 1'b0;
        w_valid_nxt   = 1'b0;
        w_a_in1_nxt   = '0;
        w_a_in2_nxt   = '0;
        w_cap_c00     = 1'b0;
        w_cap_c10_c01 = 1'b0;
        w_cap_c11     = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_snap      = 1'b1;
                    w_state_nxt = ST_LOAD;
                    w_cnt_nxt   = c_CNT_ZERO;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_FEED;
                w_cnt_nxt   = c_CNT_ZERO;
            end
            ST_FEED: begin
                // The array results for cycle Fk are sampled on the edge
                // that ends Fk.
                w_cap_c00     = (r_cnt == c_CAP0);
                w_cap_c10_c01 = (r_cnt == c_CAP1);
                w_cap_c11     = (r_cnt == c_CAP2);
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = ST_DONE;
                    w_cnt_nxt   = c_CNT_ZERO;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end
            ST_DONE: begin
                // start is deliberately not examined here; a start request
                // is taken on the following IDLE cycle.
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = c_CNT_ZERO;
            end
        endcase

        w_busy_nxt  = (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_FEED);
        w_done_nxt  = (w_state_nxt == ST_DONE);
        w_load_nxt  = (w_state_nxt == ST_LOAD);
        w_valid_nxt = (w_state_nxt == ST_FEED);

        // Skewed feed: row 1 lags row 0 by one cycle.
        if (w_state_nxt == ST_FEED) begin
            if (w_cnt_nxt == c_CNT_ZERO) begin
                w_a_in1_nxt = r_a00;
            end else if (w_cnt_nxt == c_CNT_ONE) begin
                w_a_in1_nxt = r_a10;
                w_a_in2_nxt = r_a01;
            end else if (w_cnt_nxt == c_CNT_TWO) begin
                w_a_in2_nxt = r_a11;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Snapshot, control outputs and feed data
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a00         <= '0;
            r_a01         <= '0;
            r_a10         <= '0;
            r_a11         <= '0;
            r_w1          <= '0;
            r_w2          <= '0;
            r_w3          <= '0;
            r_w4          <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_load_weight <= 1'b0;
            r_valid       <= 1'b0;
            r_a_in1       <= '0;
            r_a_in2       <= '0;
        end else begin
            if (w_snap) begin
                r_a00 <= a00;
                r_a01 <= a01;
                r_a10 <= a10;
                r_a11 <= a11;
                r_w1  <= w00;
                r_w2  <= w01;
                r_w3  <= w10;
                r_w4  <= w11;
            end
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_load_weight <= w_load_nxt;
            r_valid       <= w_valid_nxt;
            r_a_in1       <= w_a_in1_nxt;
            r_a_in2       <= w_a_in2_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Result capture: full-width accumulator values, held across runs until
    // overwritten by a later capture.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_c00 <= '0;
            r_c01 <= '0;
            r_c10 <= '0;
            r_c11 <= '0;
        end else begin
            if (w_cap_c00) begin
                r_c00 <= acc_out1;
            end
            if (w_cap_c10_c01) begin
                r_c10 <= acc_out1;
                r_c01 <= acc_out2;
            end
            if (w_cap_c11) begin
                r_c11 <= acc_out2;
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign load_weight = r_load_weight;
    assign valid       = r_valid;
    assign a_in1       = r_a_in1;
    assign a_in2       = r_a_in2;
    assign weight1     = r_w1;
    assign weight2     = r_w2;
    assign weight3     = r_w3;
    assign weight4     = r_w4;
    assign c00         = r_c00;
    assign c01         = r_c01;
    assign c10         = r_c10;
    assign c11         = r_c11;

endmodule
`default_nettype wire

// File: tb/tb_mmu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mmu_seq_ctrl
//  Purpose  : Self-checking bench for mmu_seq_ctrl. Two instances are used:
//             one with the default pipeline depth and one with depth 3, each
//             attached to a behavioural 2x2 weight-stationary array model.
//             Results are compared against a plain matrix product.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mmu_seq_ctrl;

    localparam int MAXC = 30;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start1 = 1'b0;
    logic        start2 = 1'b0;
    logic [15:0] a00 = '0, a01 = '0, a10 = '0, a11 = '0;
    logic [15:0] w00 = '0, w01 = '0, w10 = '0, w11 = '0;

    // DUT1 (depth 2) signals
    logic        d1_busy, d1_done, d1_lw, d1_valid;
    logic [15:0] d1_a1, d1_a2, d1_w1, d1_w2, d1_w3, d1_w4;
    logic [31:0] d1_acc1, d1_acc2, d1_c00, d1_c01, d1_c10, d1_c11;
    // DUT2 (depth 3) signals
    logic        d2_busy, d2_done, d2_lw, d2_valid;
    logic [15:0] d2_a1, d2_a2, d2_w1, d2_w2, d2_w3, d2_w4;
    logic [31:0] d2_acc1, d2_acc2, d2_c00, d2_c01, d2_c10, d2_c11;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mmu_seq_ctrl #(.DATA_W(16), .ACC_W(32), .CAP_OFFSET(2)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .a00(a00), .a01(a01), .a10(a10), .a11(a11),
        .w00(w00), .w01(w01), .w10(w10), .w11(w11),
        .busy(d1_busy), .done(d1_done), .load_weight(d1_lw), .valid(d1_valid),
        .a_in1(d1_a1), .a_in2(d1_a2),
        .weight1(d1_w1), .weight2(d1_w2), .weight3(d1_w3), .weight4(d1_w4),
        .acc_out1(d1_acc1), .acc_out2(d1_acc2),
        .c00(d1_c00), .c01(d1_c01), .c10(d1_c10), .c11(d1_c11)
    );

    mmu_seq_ctrl #(.DATA_W(16), .ACC_W(32), .CAP_OFFSET(3)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2),
        .a00(a00), .a01(a01), .a10(a10), .a11(a11),
        .w00(w00), .w01(w01), .w10(w10), .w11(w11),
        .busy(d2_busy), .done(d2_done), .load_weight(d2_lw), .valid(d2_valid),
        .a_in1(d2_a1), .a_in2(d2_a2),
        .weight1(d2_w1), .weight2(d2_w2), .weight3(d2_w3), .weight4(d2_w4),
        .acc_out1(d2_acc1), .acc_out2(d2_acc2),
        .c00(d2_c00), .c01(d2_c01), .c10(d2_c10), .c11(d2_c11)
    );

    // ------------------------------------------------------------------------
    // Behavioural array models. h[k] is the activation presented k cycles
    // ago (zero when valid was low). Column 0 sums row 0 delayed by the
    // depth D and row 1 delayed by D-1; column 1 sits one cycle further on.
    // ------------------------------------------------------------------------
    logic [15:0] m1_h1 [1:4];
    logic [15:0] m1_h2 [1:4];
    logic [15:0] m1_w  [0:3];
    logic [15:0] m2_h1 [1:4];
    logic [15:0] m2_h2 [1:4];
    logic [15:0] m2_w  [0:3];

    initial begin
        for (int k = 1; k <= 4; k++) begin
            m1_h1[k] = '0; m1_h2[k] = '0; m2_h1[k] = '0; m2_h2[k] = '0;
        end
        for (int k = 0; k < 4; k++) begin
            m1_w[k] = '0; m2_w[k] = '0;
        end
    end

    always @(posedge clk) begin
        if (d1_lw) begin
            m1_w[0] <= d1_w1; m1_w[1] <= d1_w2; m1_w[2] <= d1_w3; m1_w[3] <= d1_w4;
        end
        if (d2_lw) begin
            m2_w[0] <= d2_w1; m2_w[1] <= d2_w2; m2_w[2] <= d2_w3; m2_w[3] <= d2_w4;
        end
        m1_h1[1] <= d1_valid ? d1_a1 : 16'h0;
        m1_h2[1] <= d1_valid ? d1_a2 : 16'h0;
        m2_h1[1] <= d2_valid ? d2_a1 : 16'h0;
        m2_h2[1] <= d2_valid ? d2_a2 : 16'h0;
        for (int k = 2; k <= 4; k++) begin
            m1_h1[k] <= m1_h1[k-1]; m1_h2[k] <= m1_h2[k-1];
            m2_h1[k] <= m2_h1[k-1]; m2_h2[k] <= m2_h2[k-1];
        end
    end

    assign d1_acc1 = 32'(m1_h1[2]) * 32'(m1_w[0]) + 32'(m1_h2[1]) * 32'(m1_w[2]);
    assign d1_acc2 = 32'(m1_h1[3]) * 32'(m1_w[1]) + 32'(m1_h2[2]) * 32'(m1_w[3]);
    assign d2_acc1 = 32'(m2_h1[3]) * 32'(m2_w[0]) + 32'(m2_h2[2]) * 32'(m2_w[2]);
    assign d2_acc2 = 32'(m2_h1[4]) * 32'(m2_w[1]) + 32'(m2_h2[3]) * 32'(m2_w[3]);

    // Reference: C[i][j] = sum_k A[i][k] * W[k][j], modulo 2^32
    logic [15:0] ra [0:1][0:1];
    logic [15:0] rw [0:1][0:1];

    function automatic logic [31:0] ref_c(input int i, input int j);
        logic [31:0] s;
        s = '0;
        for (int k = 0; k < 2; k++) s += 32'(ra[i][k]) * 32'(rw[k][j]);
        return s;
    endfunction

    task automatic set_ops(input logic [15:0] x00, x01, x10, x11,
                           input logic [15:0] y00, y01, y10, y11);
        a00 = x00; a01 = x01; a10 = x10; a11 = x11;
        w00 = y00; w01 = y01; w10 = y10; w11 = y11;
        ra[0][0] = x00; ra[0][1] = x01; ra[1][0] = x10; ra[1][1] = x11;
        rw[0][0] = y00; rw[0][1] = y01; rw[1][0] = y10; rw[1][1] = y11;
    endtask

    // Per-cycle record of the last run on DUT1 (index = cycles after start edge)
    logic        s_lw [0:MAXC];
    logic        s_v  [0:MAXC];
    logic [15:0] s_a1 [0:MAXC];
    logic [15:0] s_a2 [0:MAXC];
    logic [63:0] s_wt [0:MAXC];

    // One run on the selected instance. Called just after a rising edge;
    // returns just after a rising edge.
    task automatic do_run(input int dut, output int done_cyc, output int busy_n,
                          output int done_n, output int valid_n);
        logic b, d, v;
        done_cyc = -1; busy_n = 0; done_n = 0; valid_n = 0;
        if (dut == 1) start1 = 1'b1; else start2 = 1'b1;
        for (int cyc = 1; cyc <= MAXC; cyc++) begin
            @(posedge clk); #1;
            start1 = 1'b0; start2 = 1'b0;
            b = (dut == 1) ? d1_busy  : d2_busy;
            d = (dut == 1) ? d1_done  : d2_done;
            v = (dut == 1) ? d1_valid : d2_valid;
            s_lw[cyc] = d1_lw; s_v[cyc] = d1_valid;
            s_a1[cyc] = d1_a1; s_a2[cyc] = d1_a2;
            s_wt[cyc] = {d1_w1, d1_w2, d1_w3, d1_w4};
            if (b) busy_n++;
            if (v) valid_n++;
            if (d) begin
                done_n++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc > 0 && cyc >= done_cyc + 2) break;
        end
        if (done_cyc < 0) begin
            total++; bad++;
            $display("FAIL run_timeout dut=%0d: done not seen within %0d cycles", dut, MAXC);
        end
    endtask

    task automatic check_results(input string tag, input int dut);
        logic [31:0] got [0:1][0:1];
        got[0][0] = (dut == 1) ? d1_c00 : d2_c00;
        got[0][1] = (dut == 1) ? d1_c01 : d2_c01;
        got[1][0] = (dut == 1) ? d1_c10 : d2_c10;
        got[1][1] = (dut == 1) ? d1_c11 : d2_c11;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                total++;
                if (got[i][j] !== ref_c(i, j)) begin
                    bad++;
                    $display("FAIL %s c%0d%0d: got %h expected %h", tag, i, j, got[i][j], ref_c(i, j));
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        total++;
        if ({d1_busy, d1_done, d1_lw, d1_valid} !== 4'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b expected 0000", {d1_busy, d1_done, d1_lw, d1_valid});
        end
        total++;
        if ({d1_a1, d1_a2, d1_w1, d1_w2, d1_w3, d1_w4} !== 96'h0) begin
            bad++; $display("FAIL reset_data: got %h expected 0", {d1_a1, d1_a2, d1_w1, d1_w2, d1_w3, d1_w4});
        end
        total++;
        if ({d1_c00, d1_c01, d1_c10, d1_c11} !== 128'h0) begin
            bad++; $display("FAIL reset_c: got %h expected 0", {d1_c00, d1_c01, d1_c10, d1_c11});
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int dc, bn, dn, vn;
        set_ops(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8);
        do_run(1, dc, bn, dn, vn);
        check_results("basic", 1);
        total++;
        if (d1_c01 !== 32'd22) begin bad++; $display("FAIL basic_c01_const: got %0d expected 22", d1_c01); end
        total++;
        if (dc !== 7) begin bad++; $display("FAIL basic_latency: got %0d expected 7", dc); end
        total++;
        if (bn !== 6) begin bad++; $display("FAIL basic_busy_cycles: got %0d expected 6", bn); end
        total++;
        if (dn !== 1) begin bad++; $display("FAIL basic_done_width: got %0d expected 1", dn); end
    endtask

    // Inspects the array-side signals recorded by the preceding basic run.
    task automatic test_sequence();
        logic [15:0] ea1 [0:4];
        logic [15:0] ea2 [0:4];
        int lw_n;
        ea1[0] = 16'd1; ea1[1] = 16'd3; ea1[2] = 16'd0; ea1[3] = 16'd0; ea1[4] = 16'd0;
        ea2[0] = 16'd0; ea2[1] = 16'd2; ea2[2] = 16'd4; ea2[3] = 16'd0; ea2[4] = 16'd0;
        lw_n = 0;
        for (int c = 1; c <= 7; c++) if (s_lw[c]) lw_n++;
        total++;
        if (lw_n !== 1 || s_lw[1] !== 1'b1) begin
            bad++; $display("FAIL seq_load_weight: count %0d lw@1=%b expected 1 at cycle 1", lw_n, s_lw[1]);
        end
        total++;
        if (s_wt[1] !== {16'd5, 16'd6, 16'd7, 16'd8}) begin
            bad++; $display("FAIL seq_weights: got %h expected 0005000600070008", s_wt[1]);
        end
        total++;
        if (s_v[1] !== 1'b0 || s_a1[1] !== 16'h0 || s_a2[1] !== 16'h0) begin
            bad++; $display("FAIL seq_load_idle_feed: valid=%b a1=%0d a2=%0d expected 0,0,0", s_v[1], s_a1[1], s_a2[1]);
        end
        for (int f = 0; f < 5; f++) begin
            total++;
            if ({s_v[f+2], s_a1[f+2], s_a2[f+2]} !== {1'b1, ea1[f], ea2[f]}) begin
                bad++;
                $display("FAIL seq_feed_F%0d: valid=%b a1=%0d a2=%0d expected 1,%0d,%0d",
                         f, s_v[f+2], s_a1[f+2], s_a2[f+2], ea1[f], ea2[f]);
            end
        end
        total++;
        if (s_v[7] !== 1'b0) begin bad++; $display("FAIL seq_valid_done: got %b expected 0", s_v[7]); end
    endtask

    // start held high: runs must be separated by exactly one IDLE cycle.
    task automatic test_back_to_back();
        int dcy [$];
        int lcy [$];
        set_ops(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8);
        start1 = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) begin
                // Changed after the first snapshot; only the second run sees it.
                a00 = 16'd2; a01 = 16'd0; a10 = 16'd0; a11 = 16'd2;
            end
            if (d1_lw) lcy.push_back(cyc);
            if (d1_done) begin
                dcy.push_back(cyc);
                if (dcy.size() == 1) check_results("b2b_run1", 1);
                if (dcy.size() == 2) begin
                    ra[0][0] = 16'd2; ra[0][1] = 16'd0; ra[1][0] = 16'd0; ra[1][1] = 16'd2;
                    check_results("b2b_run2", 1);
                    start1 = 1'b0;
                end
            end
        end
        start1 = 1'b0;
        total++;
        if (dcy.size() != 2 || dcy[0] != 7 || dcy[1] != 15) begin
            bad++; $display("FAIL b2b_done_cycles: got n=%0d first=%0d expected 2 pulses at 7,15",
                            dcy.size(), (dcy.size() > 0) ? dcy[0] : -1);
        end
        total++;
        if (lcy.size() != 2 || lcy[0] != 1 || lcy[1] != 9) begin
            bad++; $display("FAIL b2b_load_cycles: got n=%0d second=%0d expected loads at 1,9",
                            lcy.size(), (lcy.size() > 1) ? lcy[1] : -1);
        end
    endtask

    task automatic test_reset_mid();
        int dc, bn, dn, vn;
        int done_seen;
        set_ops(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8);
        start1 = 1'b1;
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(posedge clk); #1;
            start1 = 1'b0;
        end
        // Now in F1; assert reset between edges.
        #2;
        reset = 1'b0;
        #1;
        total++;
        if ({d1_busy, d1_done, d1_lw, d1_valid, d1_a1, d1_a2} !== 36'h0) begin
            bad++; $display("FAIL rstmid_ctrl: got %h expected 0", {d1_busy, d1_done, d1_lw, d1_valid, d1_a1, d1_a2});
        end
        total++;
        if ({d1_w1, d1_w2, d1_w3, d1_w4, d1_c00, d1_c01, d1_c10, d1_c11} !== 192'h0) begin
            bad++; $display("FAIL rstmid_data: got %h expected 0", {d1_w1, d1_w2, d1_w3, d1_w4});
        end
        done_seen = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 3) reset = 1'b1;
            if (d1_done) done_seen++;
        end
        total++;
        if (done_seen != 0) begin bad++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", done_seen); end
        do_run(1, dc, bn, dn, vn);
        check_results("rstmid_rerun", 1);
        total++;
        if (dc !== 7) begin bad++; $display("FAIL rstmid_latency: got %0d expected 7", dc); end
    endtask

    task automatic test_extreme();
        int dc, bn, dn, vn;
        set_ops(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        do_run(1, dc, bn, dn, vn);
        check_results("extreme", 1);
        total++;
        if (d1_c11 !== 32'hFFFC0002) begin bad++; $display("FAIL extreme_c11_const: got %h expected fffc0002", d1_c11); end
    endtask

    task automatic test_random();
        int dc, bn, dn, vn;
        for (int r = 0; r < 6; r++) begin
            set_ops(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            do_run(1, dc, bn, dn, vn);
            check_results("random", 1);
            total++;
            if (dc !== 7) begin bad++; $display("FAIL random_latency run %0d: got %0d expected 7", r, dc); end
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_cap3();
        int dc, bn, dn, vn;
        for (int r = 0; r < 3; r++) begin
            if (r == 0) set_ops(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8);
            else set_ops(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                         16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            do_run(2, dc, bn, dn, vn);
            check_results("cap3", 2);
            total++;
            if (dc !== 8) begin bad++; $display("FAIL cap3_latency: got %0d expected 8", dc); end
            total++;
            if (vn !== 6) begin bad++; $display("FAIL cap3_feed_cycles: got %0d expected 6", vn); end
            total++;
            if (bn !== 7) begin bad++; $display("FAIL cap3_busy_cycles: got %0d expected 7", bn); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sequence();
        test_back_to_back();
        test_reset_mid();
        test_extreme();
        test_random();
        test_cap3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
